// File: rtl/divider_seq_ctrl.sv
// divider_seq_ctrl: 16/8 restoring divider that reuses one 8-cell subtractor row over 8 cycles.
// Define DIV_EXACT_OVERRIDE_EN to add exact_mode, which forces exact cells for a request.
module divider_seq_ctrl #(
   parameter int APPROX_ROWS = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] n,
   input  logic [7:0]  d,
`ifdef DIV_EXACT_OVERRIDE_EN
   input  logic        exact_mode,
`endif
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  q,
   output logic [7:0]  r,
   output logic        dz,
   output logic        ovf
);
   typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
   state_t state, state_nx;
   logic [2:0] k;
   logic [8:0] w;
   logic [6:0] nl;
   logic [7:0] dl, diff, rem;
   logic [8:0] bc;
   logic em, approx, qbit;
   assign bc[0] = 1'b0;
   genvar i;
   generate
      for (i = 0; i < 8; i++) begin : g_cell
         // approx cell differs from exact only at x=0,y=1,b=1, where it outputs 1
         assign diff[i]  = (w[i] ^ dl[i] ^ bc[i]) | (approx & ~w[i] & dl[i] & bc[i]);
         assign bc[i+1]  = (~w[i] & dl[i]) | (~(w[i] ^ dl[i]) & bc[i]);
      end
   endgenerate
   assign approx    = (int'(k) < APPROX_ROWS) & ~em;
   assign qbit      = w[8] | ~bc[8];
   assign rem       = qbit ? diff : w[7:0];
   assign in_ready  = state == IDLE;
   assign out_valid = state == DONE;
`ifndef DIV_EXACT_OVERRIDE_EN
   assign em = 1'b0;
`endif
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = in_valid ? ((d == 8'd0) ? DONE : ITER) : IDLE;
         ITER:    state_nx = (k == 3'd0) ? DONE : ITER;
         DONE:    state_nx = out_ready ? IDLE : DONE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k   <= 3'd0;
         w   <= 9'd0;
         nl  <= 7'd0;
         dl  <= 8'd0;
         q   <= 8'd0;
         r   <= 8'd0;
         dz  <= 1'b0;
         ovf <= 1'b0;
`ifdef DIV_EXACT_OVERRIDE_EN
         em  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               k   <= 3'd7;
               w   <= n[15:7];
               nl  <= n[6:0];
               dl  <= d;
               dz  <= d == 8'd0;
               ovf <= (n[15:8] >= d) && (d != 8'd0);
               q   <= (d == 8'd0) ? 8'hFF : 8'd0;
               r   <= (d == 8'd0) ? n[7:0] : 8'd0;
`ifdef DIV_EXACT_OVERRIDE_EN
               em  <= exact_mode;
`endif
            end
            ITER: begin
               q[k] <= qbit;
               if (k == 3'd0) r <= rem;
               else begin
                  w <= {rem, nl[k - 3'd1]};
                  k <= k - 3'd1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
